// File: rtl/button_pkg.sv
// Shared types and defaults for the push-button front end.
// Holds the debounce FSM state encoding and default cycle counts.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'b00,
        PRESS_WAIT   = 2'b01,
        PRESSED      = 2'b10,
        RELEASE_WAIT = 2'b11
    } btn_state_t;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 1000000;
    localparam int unsigned LONG_CYCLES_DEF     = 50000000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous pad input.
// Ports: clk, rst (async active-low), i_d (raw), o_q (synchronised).
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_s1;
    logic r_s2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;

endmodule

// File: rtl/button_debouncer.sv
// Push-button conditioner: 2FF sync + 4-state debounce FSM with
// registered level and one-cycle rise/fall pulses.
// Ports: clk, rst (async active-low), btn_in (raw pad),
//        btn_level, btn_rise, btn_fall, btn_long.
// Optional long-press pulse enabled by macro BTN_LONG_PRESS_EN;
// without it btn_long is tied to 0.
module button_debouncer
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned LONG_CYCLES     = LONG_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_rise,
    output logic btn_fall,
    output logic btn_long
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             w_s2;
    btn_state_t       r_state;
    btn_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_level;
    logic             w_level_nxt;
    logic             r_rise;
    logic             w_rise_nxt;
    logic             r_fall;
    logic             w_fall_nxt;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (btn_in),
        .o_q (w_s2)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_level <= w_level_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
        end
    end

    // Any sample at the old level inside a WAIT state abandons the
    // qualification; re-entry clears cnt, so bounce restarts it.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_level_nxt = r_level;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_s2) begin
                    w_state_nxt = PRESS_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!w_s2) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = PRESSED;
                    w_level_nxt = 1'b1;
                    w_rise_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (!w_s2) begin
                    w_state_nxt = RELEASE_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (w_s2) begin
                    w_state_nxt = PRESSED;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = IDLE;
                    w_level_nxt = 1'b0;
                    w_fall_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
        endcase
    end

    assign btn_level = r_level;
    assign btn_rise  = r_rise;
    assign btn_fall  = r_fall;

`ifdef BTN_LONG_PRESS_EN
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES);

    logic [HOLD_W-1:0] r_hold;
    logic [HOLD_W-1:0] w_hold_nxt;
    logic [HOLD_W-1:0] w_hold_inc;
    logic              r_long;
    logic              w_long_nxt;

    assign w_hold_inc = r_hold + 1'b1;

    // Counts through PRESSED and RELEASE_WAIT so a rejected release
    // does not restart the hold; saturates at LONG_CYCLES.
    always_comb begin
        w_hold_nxt = r_hold;
        w_long_nxt = 1'b0;
        if (w_rise_nxt || w_fall_nxt) begin
            w_hold_nxt = '0;
        end else if ((r_state == PRESSED || r_state == RELEASE_WAIT)
                     && r_hold != HOLD_LAST) begin
            w_hold_nxt = w_hold_inc;
            w_long_nxt = (w_hold_inc == HOLD_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold <= '0;
            r_long <= 1'b0;
        end else begin
            r_hold <= w_hold_nxt;
            r_long <= w_long_nxt;
        end
    end

    assign btn_long = r_long;
`else
    logic w_unused_long;
    assign w_unused_long = ^LONG_CYCLES;
    assign btn_long = 1'b0;
`endif

endmodule
